// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter                                            |
// | Description : Round-robin write arbiter sharing one FIFO write port      |
// |               among N_REQ valid/ready requesters. Never writes while     |
// |               the FIFO reports full.                                     |
// |               Optional packet lock: define FIFO_ARB_LOCK_EN to keep the  |
// |               grant on one requester until its req_last beat.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data_in,
    input  logic                     fifo_full,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     locked
);

    localparam int C_IW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    logic [C_IW-1:0] ptr_q;
    logic [C_IW-1:0] grant_q;
    logic            locked_q;

    logic            w_win_vld;
    logic [C_IW-1:0] w_win_idx;
    logic            w_xfer;
    logic [C_IW-1:0] w_ptr_d;

    // Index reached by stepping 'off' places forward from 'base', modulo N_REQ.
    function automatic logic [C_IW-1:0] rr_idx(input logic [C_IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return C_IW'(s);
    endfunction

    // Winner selection: owner only while locked, otherwise first valid from ptr onward.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        if (state_q == ST_LOCKED) begin
            w_win_vld = req_valid[grant_q];
            w_win_idx = grant_q;
        end else begin
            // Scan from the far end so the entry closest to ptr is the one kept.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req_valid[rr_idx(ptr_q, k)]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = rr_idx(ptr_q, k);
                end
            end
        end
    end

    // A beat moves only with a winner, room in the FIFO and reset released.
    assign w_xfer  = w_win_vld & ~fifo_full & ~rst;
    assign w_ptr_d = (w_win_idx == C_IW'(N_REQ - 1)) ? '0 : (w_win_idx + 1'b1);

    // Drive the FIFO write port and the one-hot ready from the selected beat.
    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        if (w_xfer) begin
            req_ready[w_win_idx] = 1'b1;
            fifo_data_in         = req_data[int'(w_win_idx) * WIDTH +: WIDTH];
        end
    end

    assign fifo_wr_en = w_xfer;
    assign grant_id   = grant_q;
    assign locked     = locked_q;

    // Grant FSM: pointer, last winner and packet lock advance on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
        end else if (w_xfer) begin
            grant_q <= w_win_idx;
`ifdef FIFO_ARB_LOCK_EN
            if (req_last[w_win_idx]) begin
                state_q  <= ST_IDLE;
                ptr_q    <= w_ptr_d;
                locked_q <= 1'b0;
            end else begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
            end
`else
            state_q  <= ST_IDLE;
            ptr_q    <= w_ptr_d;
            locked_q <= 1'b0;
`endif
        end
    end

`ifndef FIFO_ARB_LOCK_EN
    // Packet boundaries are irrelevant when every beat is its own grant.
    logic w_unused_last;
    assign w_unused_last = ^req_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_wr_arbiter                                         |
// | Description : Self-checking bench for fifo_wr_arbiter (N_REQ=4, W=8).   |
// |               Lock scenarios are included when FIFO_ARB_LOCK_EN is set.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef FIFO_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic [1:0]     grant_id;
    logic           locked;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    // Reference model: rotating priority starting at m_ptr, sticky owner while locked.
    int m_ptr  = 0;
    int m_gid  = 0;
    bit m_lock = 1'b0;

    function automatic int m_winner();
        if (rst || fifo_full) return -1;
        if (m_lock) return req_valid[m_gid] ? m_gid : -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_winner() >= 0) r[m_winner()] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] exp_data();
        if (m_winner() < 0) return '0;
        return req_data[m_winner() * W +: W];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ptr  <= 0;
            m_gid  <= 0;
            m_lock <= 1'b0;
        end else if (m_winner() >= 0) begin
            m_gid <= m_winner();
            if (LOCK_EN && !req_last[m_winner()]) begin
                m_lock <= 1'b1;
            end else begin
                m_lock <= 1'b0;
                m_ptr  <= (m_winner() + 1) % N;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready",  32'(req_ready),    32'(exp_ready()));
            chk("m_wr_en",  32'(fifo_wr_en),   32'(m_winner() >= 0));
            chk("m_data",   32'(fifo_data_in), 32'(exp_data()));
            chk("m_gid",    32'(grant_id),     32'(m_gid));
            chk("m_locked", 32'(locked),       32'(m_lock));
        end
    end

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    // One cycle of stimulus; returns with outputs settled, before the next edge.
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        rst       = r;
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '1;
        fifo_full = 1'b0;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset held with every requester valid.
        step(4'hF, 4'hF, 1'b0, 1'b1);
        chk("rst_ready",  32'(req_ready),  32'h0);
        chk("rst_wr_en",  32'(fifo_wr_en), 32'h0);
        chk("rst_gid",    32'(grant_id),   32'h0);
        chk("rst_locked", 32'(locked),     32'h0);

        // All valid: 0x10,0x11,0x12,0x13,0x10 with grant_id trailing by one cycle.
        for (int k = 0; k < 5; k++) begin
            step(4'hF, 4'hF, 1'b0, 1'b0);
            chk("t1_data", 32'(fifo_data_in), 32'h10 + 32'(k % 4));
            if (k > 0) chk("t1_gid", 32'(grant_id), 32'((k - 1) % 4));
        end

        // Only req 2 valid, FIFO full in the middle cycle.
        step(4'b0100, 4'hF, 1'b0, 1'b0);
        chk("t2_gid0",   32'(grant_id),     32'h0);
        chk("t2_ready1", 32'(req_ready),    32'b0100);
        chk("t2_data1",  32'(fifo_data_in), 32'h12);
        step(4'b0100, 4'hF, 1'b1, 1'b0);
        chk("t2_ready2", 32'(req_ready),    32'h0);
        chk("t2_wr_en2", 32'(fifo_wr_en),   32'h0);
        chk("t2_gid2",   32'(grant_id),     32'h2);
        step(4'b0100, 4'hF, 1'b0, 1'b0);
        chk("t2_ready3", 32'(req_ready),    32'b0100);
        chk("t2_data3",  32'(fifo_data_in), 32'h12);

        // ptr is 3: req 3 wins, pointer wraps, req 0 wins next.
        step(4'b1001, 4'hF, 1'b0, 1'b0);
        chk("t3_ready1", 32'(req_ready),    32'b1000);
        chk("t3_data1",  32'(fifo_data_in), 32'h13);
        step(4'b1001, 4'hF, 1'b0, 1'b0);
        chk("t3_ready2", 32'(req_ready),    32'b0001);
        chk("t3_gid2",   32'(grant_id),     32'h3);

        // Nobody valid: no write, state held.
        step(4'b0000, 4'hF, 1'b0, 1'b0);
        chk("idle_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("idle_gid",   32'(grant_id),   32'h0);

        // Fairness: ptr is 1, so grants run 1,2,3,0,1,2,3,0.
        set_data(8'h5A, 8'hC3, 8'h3C, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 4'hF, 1'b0, 1'b0);
            chk("fair_ready", 32'(req_ready), 32'(1) << ((k + 1) % 4));
        end

`ifdef FIFO_ARB_LOCK_EN
        // Req 1 sends a 3-beat packet while req 0 stays valid.
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        step(4'b0011, 4'b1101, 1'b0, 1'b0);
        chk("t4_ready1",  32'(req_ready), 32'b0010);
        chk("t4_locked1", 32'(locked),    32'h0);
        step(4'b0011, 4'b1101, 1'b0, 1'b0);
        chk("t4_ready2",  32'(req_ready), 32'b0010);
        chk("t4_locked2", 32'(locked),    32'h1);
        step(4'b0011, 4'b1111, 1'b0, 1'b0);
        chk("t4_ready3",  32'(req_ready), 32'b0010);
        chk("t4_locked3", 32'(locked),    32'h1);
        step(4'b0001, 4'b1111, 1'b0, 1'b0);
        chk("t4_ready4",  32'(req_ready),    32'b0001);
        chk("t4_data4",   32'(fifo_data_in), 32'hA0);
        chk("t4_locked4", 32'(locked),       32'h0);

        // Owner req 1 goes quiet mid-packet; req 2 must not get in.
        step(4'b0110, 4'b1101, 1'b0, 1'b0);
        chk("t5_ready1", 32'(req_ready), 32'b0010);
        for (int k = 0; k < 2; k++) begin
            step(4'b0100, 4'b1101, 1'b0, 1'b0);
            chk("t5_ready_gap",  32'(req_ready),  32'h0);
            chk("t5_wr_en_gap",  32'(fifo_wr_en), 32'h0);
            chk("t5_locked_gap", 32'(locked),     32'h1);
        end
        step(4'b0110, 4'b1101, 1'b0, 1'b0);
        chk("t5_ready4", 32'(req_ready), 32'b0010);
`endif

        // Reset in the middle of traffic, then req 0 wins from ptr 0.
        step(4'hF, 4'hF, 1'b0, 1'b1);
        chk("t6_rst_ready", 32'(req_ready),  32'h0);
        chk("t6_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        step(4'b0011, 4'hF, 1'b0, 1'b0);
        chk("t6_locked", 32'(locked),    32'h0);
        chk("t6_gid",    32'(grant_id),  32'h0);
        chk("t6_ready",  32'(req_ready), 32'b0001);

        step(4'b0000, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port among `N_REQ` requesters. Each requester presents a valid/ready stream; the arbiter selects one per cycle, drives the FIFO's `wr_en`/`data_in` and honours `full` so no write is ever issued to a full FIFO. It sits directly in front of the `fifo` instance. The read side is not touched.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `WIDTH`, 8, data width; must match the FIFO `WIDTH`

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  requester i has a beat
- `req_data`  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- `req_last`  in  N_REQ  last beat of requester i's packet (used only with lock)
- `req_ready`  out  N_REQ  one-hot or zero; beat i accepted this cycle
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_data_in`  out  WIDTH  to FIFO `data_in`
- `fifo_full`  in  1  from FIFO `full`
- `grant_id`  out  $clog2(N_REQ)  index of current/last winner
- `locked`  out  1  a packet lock is held (always 0 without lock feature)

## Operation
- Registered state: round-robin pointer `ptr` (0..N_REQ-1), `grant_id`, FSM state (IDLE, LOCKED).
- Winner selection (combinational): first i with `req_valid[i]` scanning `ptr, ptr+1, ... , ptr+N_REQ-1` mod N_REQ.
- Beat transfer in a cycle iff a winner exists and `fifo_full`=0: `req_ready[win]`=1, `fifo_wr_en`=1, `fifo_data_in`=`req_data[win]`. Otherwise `req_ready`=0, `fifo_wr_en`=0, `fifo_data_in`=0.
- At most one `req_ready` bit high per cycle; `fifo_wr_en` == |`req_ready`.
- Pointer update after a beat that ends a grant: `ptr` <= (win+1) mod N_REQ (wrap from N_REQ-1 to 0). `grant_id` <= win on every accepted beat.
- `fifo_full`=1: no transfer; `ptr`, `grant_id`, state held.
- No valid requesters: no transfer; state held.
- FSM (lock feature only):
  - IDLE: accepted beat with `req_last`=0 -> LOCKED, owner = win. Beat with `req_last`=1 -> stay IDLE, advance `ptr`.
  - LOCKED: only owner (`grant_id`) eligible; others get `req_ready`=0 regardless of `ptr`. Owner `req_valid`=0 -> idle cycle, stay LOCKED. Owner beat with `req_last`=1 -> IDLE, `ptr` <= owner+1.
- Reset values: `ptr`=0, `grant_id`=0, state IDLE, `locked`=0; outputs `req_ready`=0, `fifo_wr_en`=0 while `rst`=1 and in the reset cycle's outputs regardless of inputs.
- Reset mid-packet: lock dropped, next cycle is IDLE with `ptr`=0; partial packet in the FIFO is not rolled back.

## Timing
- Zero-cycle latency: `req_valid` -> `req_ready`/`fifo_wr_en` combinational in the same cycle; data written by FIFO on that edge.
- `fifo_full` -> `fifo_wr_en` combinational; full must be the FIFO's registered flag (no loop).
- Fairness: with all requesters continuously valid and FIFO never full, each gets exactly one grant (one packet with lock) per N_REQ grants.
- State/pointer update on the rising edge following the accepted beat.

## Configuration
- `FIFO_ARB_LOCK_EN` defined: packet lock enabled; IDLE/LOCKED FSM as above; `locked`=1 while in LOCKED.
- Not defined: every beat is an independent grant; `req_last` ignored; FSM stays IDLE; `locked` tied 0; `ptr` advances after every accepted beat.

## Test plan
- Reset then all 4 valid, data i = 0x10+i, FIFO never full -> writes 0x10,0x11,0x12,0x13,0x10 on consecutive cycles; `grant_id` 0,1,2,3,0.
- Only req 2 valid for 3 cycles, `fifo_full`=1 in cycle 2 -> writes in cycles 1 and 3 only; `req_ready[2]`=0 and `ptr` unchanged in cycle 2.
- `ptr`=3, reqs 0 and 3 valid -> req 3 wins, then `ptr` wraps to 0 and req 0 wins next cycle.
- Lock enabled: req 1 sends 3 beats (`last` on 3rd) while req 0 valid continuously -> beats 1,1,1 then req 0; `locked`=1 for cycles 2-3.
- Lock enabled: owner req 1 drops valid for 2 cycles mid-packet with req 2 valid -> no writes for 2 cycles, req 2 `req_ready`=0, lock held.
- Assert `rst` mid-packet (lock held) -> next cycle `locked`=0, `grant_id`=0, req 0 wins if valid.
